prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have ports: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 The block SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have ports: start  in  1  one-cycle request to begin a program load.
REQ-004 The block SHALL have ports: abort  in  1  synchronous cancel of a load in progress.
REQ-005 The block SHALL have ports: in_valid  in  1  host byte valid; in_data  in  8  host byte.
REQ-006 The block SHALL have ports: in_ready  out  1  block can accept in_data this cycle.
REQ-007 The block SHALL have ports: prog_mode  out  1  halts the CPU control decoder while RAM is being written.
REQ-008 The block SHALL have ports: ram_addr  out  4  RAM write address; ram_data  out  8  RAM write data; ram_we  out  1  RAM write strobe.
REQ-009 The block SHALL have ports: busy  out  1  load in progress; done  out  1  load finished; err  out  1  checksum mismatch.

Function
REQ-010 A byte SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-011 All outputs SHALL be registered.
REQ-012 The FSM SHALL have the states IDLE, LEN, DATA, WRITE, CSUM and FIN.
REQ-013 In IDLE, start=1 SHALL move the FSM to LEN, set busy=1 and prog_mode=1, clear done, err, the address counter and the checksum accumulator.
REQ-014 In LEN, the accepted byte SHALL set the remaining count to in_data[3:0], where 0 means 16; in_data[7:4] SHALL be ignored; the FSM then moves to DATA.
REQ-015 In DATA, the accepted byte SHALL be latched to ram_data, added mod 256 to the accumulator, and the FSM moves to WRITE.
REQ-016 WRITE SHALL last exactly one cycle with ram_we=1, ram_addr = counter and in_ready=0.
REQ-017 On leaving WRITE, the counter SHALL increment and the remaining count SHALL decrement; the FSM goes to CSUM if the remaining count reaches 0, otherwise to DATA.
REQ-018 in_ready SHALL be 1 only in LEN, DATA and CSUM.
REQ-019 In CSUM, on the accepted byte: err = (in_data != accumulator); done=1; busy=0; prog_mode=0; the FSM moves to FIN.
REQ-020 In FIN, done and err SHALL hold until the next accepted start; start in FIN SHALL behave as in IDLE.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 abort=1 in any busy state SHALL return the FSM to IDLE next cycle with busy=0, prog_mode=0, ram_we=0, done=0 and err=0. abort SHALL take priority over start and over a byte accepted in the same cycle.
REQ-023 ram_we SHALL never be asserted outside WRITE.
REQ-024 ram_addr SHALL wrap 15->0 only by the count limit; a 16-byte load SHALL write addresses 0..15 exactly once each.
REQ-025 Minimum load latency SHALL be 1 (LEN) + 2N (DATA+WRITE) + 1 (CSUM) accepted-cycle slots; done rises the cycle after the checksum byte is accepted.
REQ-026 ram_data SHALL hold its last value outside WRITE.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, with in_ready, prog_mode, ram_we, busy, done and err all 0, ram_addr=0, ram_data=0, the counter and the accumulator cleared.
REQ-028 Reset asserted mid-load SHALL abandon the load with no further ram_we.
REQ-029 After rst returns to 1, the block SHALL require a new start.

Verification
REQ-030 Basic load scenario: start; bytes 0x03, 0x1E, 0x2F, 0xE0, csum 0x2D -> three ram_we pulses at addr 0,1,2 with data 0x1E, 0x2F, 0xE0; done=1, err=0; prog_mode high from the cycle after start until done.
REQ-031 Bad checksum scenario: same load as REQ-030 with csum 0x2C -> done=1, err=1; the RAM writes still occur.
REQ-032 Full-length scenario: length byte 0x00 followed by 16 bytes 0x01 and csum 0x10 -> 16 writes at addresses 0..15; done=1, err=0; ram_addr never exceeds 15.
REQ-033 Backpressure scenario: in_valid held high continuously -> in_ready=0 during each WRITE cycle; no byte is lost or duplicated.
REQ-034 Abort scenario: abort after the second data byte -> next cycle IDLE, prog_mode=0, busy=0, no further ram_we; a following start runs a clean load.
REQ-035 Reset scenario: rst=0 asserted during WRITE -> ram_we=0 immediately; all outputs at their reset values; start while busy is ignored.

Source files
------------

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Loads a short program from a byte-serial host link into a 16-entry RAM.
// A load is framed as: one length byte (low nibble, 0 encodes 16), then
// that many data bytes, then one checksum byte. The checksum is the mod-256
// sum of the data bytes. While a load is in progress prog_mode holds the CPU
// control decoder off the RAM.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   asynchronous, active-low reset
//   start      in   one-cycle request to begin a load (ignored while busy)
//   abort      in   synchronous cancel of a load in progress
//   in_valid   in   host byte valid
//   in_data    in   host byte [7:0]
//   in_ready   out  a byte is taken on an edge where in_valid & in_ready
//   prog_mode  out  CPU decoder halt while the RAM is being written
//   ram_addr   out  RAM write address [3:0]
//   ram_data   out  RAM write data [7:0], held between writes
//   ram_we     out  RAM write strobe, one cycle per data byte
//   busy       out  load in progress
//   done       out  load finished (held until the next accepted start)
//   err        out  checksum mismatch on the finished load
//
// Every output comes straight from a flop. The registered outputs are
// computed from the next state, so they line up with the state they belong
// to rather than lagging it by a cycle.
// ---------------------------------------------------------------------------
module prog_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       prog_mode,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  // Running checksum: plain byte sum, carries discarded.
  function automatic logic [7:0] csum_add(input logic [7:0] a,
                                          input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0];
  endfunction

  // Length nibble to byte count; a zero nibble selects a full 16-byte load.
  function automatic logic [4:0] len_decode(input logic [3:0] n);
    return (n == 4'd0) ? 5'd16 : {1'b0, n};
  endfunction

  // in_ready is asserted only in states that consume a host byte.
  function automatic logic takes_byte(input logic [2:0] s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [4:0] rem_q,   rem_d;
  logic [7:0] acc_q,   acc_d;
  logic [7:0] data_q,  data_d;
  logic [3:0] addr_q,  addr_d;
  logic       we_q,    we_d;
  logic       rdy_q,   rdy_d;
  logic       pm_q,    pm_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       err_q,   err_d;
  logic       accept;

  // A byte moves only when the host offers it and we advertised readiness.
  assign accept = in_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    data_d  = data_q;
    we_d    = 1'b0;
    pm_d    = pm_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      // FIN behaves like IDLE for start; done/err survive until then.
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d = S_LEN;
          busy_d  = 1'b1;
          pm_d    = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = 4'd0;
          acc_d   = 8'd0;
          rem_d   = 5'd0;
        end
      end

      S_LEN: begin
        if (accept) begin
          rem_d   = len_decode(in_data[3:0]);
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          data_d  = in_data;
          acc_d   = csum_add(acc_q, in_data);
          we_d    = 1'b1;
          state_d = S_WRITE;
        end
      end

      // Single-cycle write slot; the strobe was raised on entry.
      // The counter wraps 15->0 only after the 16th write of a full load.
      S_WRITE: begin
        cnt_d   = cnt_q + 4'd1;
        rem_d   = rem_q - 5'd1;
        state_d = (rem_q == 5'd1) ? S_CSUM : S_DATA;
      end

      S_CSUM: begin
        if (accept) begin
          err_d   = (in_data != acc_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pm_d    = 1'b0;
          state_d = S_FIN;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        pm_d    = 1'b0;
      end
    endcase

    // Abort outranks everything else in a busy state, including a byte
    // accepted on the same edge: none of that byte's effects are kept.
    if (abort && busy_q) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      data_d  = data_q;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      pm_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    rdy_d  = takes_byte(state_d);
    addr_d = cnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rem_q   <= 5'd0;
      acc_q   <= 8'd0;
      data_q  <= 8'd0;
      addr_q  <= 4'd0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      pm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      pm_q    <= pm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = rdy_q;
  assign prog_mode = pm_q;
  assign ram_addr  = addr_q;
  assign ram_data  = data_q;
  assign ram_we    = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
